// File: rtl/elevator_scan_ctrl.sv
// SCAN-scheduled elevator controller for NUM_FLOORS floors. Requests stay latched until
// served. Door dwell and per-floor travel time are timed with down-counters.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLR_W         = 2,
    parameter int DOOR_CYCLES   = 8,
    parameter int TRAVEL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_up_btn,
    input  logic [NUM_FLOORS-1:0] hall_dwn_btn,
    input  logic [NUM_FLOORS-1:0] car_btn,
    output logic                  is_moving,
    output logic                  is_moving_up,
    output logic                  is_moving_dwn,
    output logic                  is_door_close,
    output logic [FLR_W-1:0]      current_flr,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int DCNT_W = $clog2(DOOR_CYCLES);
    localparam int TCNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [DCNT_W-1:0]     DOOR_LOAD = DCNT_W'(DOOR_CYCLES - 1);
    localparam logic [TCNT_W-1:0]     TRAV_LOAD = TCNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] ONE       = NUM_FLOORS'(1);
    localparam logic [NUM_FLOORS-1:0] TOP_BIT   = ONE << (NUM_FLOORS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR_OPEN} state_t;
    typedef enum logic {DIR_UP, DIR_DN} dir_t;

    state_t                r_state, w_state_nxt;
    dir_t                  r_dir, w_dir_nxt;
    logic [FLR_W-1:0]      r_flr, w_flr_nxt, w_nf;
    logic [TCNT_W-1:0]     r_trav_cnt, w_trav_nxt;
    logic [DCNT_W-1:0]     r_door_cnt, w_door_nxt;
    logic [NUM_FLOORS-1:0] r_req_up, r_req_dn, r_req_car;
    logic                  r_door_close, w_door_close_nxt;
    logic                  r_moving, r_moving_up, r_moving_dwn;

    logic [NUM_FLOORS-1:0] w_req_all, w_flr_oh, w_set_up, w_set_dn, w_set_mask, w_clr;
    logic                  w_here, w_above, w_below, w_ahead_nf, w_stop_nf, w_btn_here;

    assign w_req_all  = r_req_up | r_req_dn | r_req_car;
    assign w_flr_oh   = ONE << r_flr;
    assign w_set_up   = hall_up_btn & ~TOP_BIT;
    assign w_set_dn   = hall_dwn_btn & ~ONE;
    assign w_set_mask = (r_state == S_DOOR_OPEN) ? ~w_flr_oh : '1;
    assign w_btn_here = |((w_set_up | w_set_dn | car_btn) & w_flr_oh);
    assign w_here     = w_req_all[r_flr];
    assign w_nf       = (r_dir == DIR_UP) ? r_flr + FLR_W'(1) : r_flr - FLR_W'(1);

    always_comb begin
        w_above    = 1'b0;
        w_below    = 1'b0;
        w_ahead_nf = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(r_flr)) w_above = w_above | w_req_all[i];
            if (i < int'(r_flr)) w_below = w_below | w_req_all[i];
            if ((r_dir == DIR_UP) ? (i > int'(w_nf)) : (i < int'(w_nf)))
                w_ahead_nf = w_ahead_nf | w_req_all[i];
        end
    end

    // Collective stop: car calls and same-direction hall calls, or anything at the end of the sweep.
    assign w_stop_nf = r_req_car[w_nf]
                     | ((r_dir == DIR_UP) ? r_req_up[w_nf] : r_req_dn[w_nf])
                     | (w_req_all[w_nf] & ~w_ahead_nf);

    always_comb begin
        w_state_nxt      = r_state;
        w_dir_nxt        = r_dir;
        w_flr_nxt        = r_flr;
        w_trav_nxt       = r_trav_cnt;
        w_door_nxt       = r_door_cnt;
        w_door_close_nxt = r_door_close;
        case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_state_nxt = S_DOOR_OPEN;
                end else if ((r_dir == DIR_UP && w_above) || (r_dir == DIR_DN && w_below)) begin
                    w_state_nxt = S_MOVE;
                end else if (w_above) begin
                    w_dir_nxt   = DIR_UP;
                    w_state_nxt = S_MOVE;
                end else if (w_below) begin
                    w_dir_nxt   = DIR_DN;
                    w_state_nxt = S_MOVE;
                end
            end
            S_MOVE: begin
                if (r_trav_cnt == '0) begin
                    w_flr_nxt = w_nf;
                    if (w_stop_nf)       w_state_nxt = S_DOOR_OPEN;
                    else if (w_ahead_nf) w_trav_nxt  = TRAV_LOAD;
                    else                 w_state_nxt = S_IDLE;
                end else begin
                    w_trav_nxt = r_trav_cnt - TCNT_W'(1);
                end
            end
            S_DOOR_OPEN: begin
                if (w_btn_here)              w_door_nxt  = DOOR_LOAD;
                else if (r_door_cnt == '0)   w_state_nxt = S_IDLE;
                else                         w_door_nxt  = r_door_cnt - DCNT_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_MOVE && r_state != S_MOVE)           w_trav_nxt = TRAV_LOAD;
        if (w_state_nxt == S_DOOR_OPEN && r_state != S_DOOR_OPEN) w_door_nxt = DOOR_LOAD;
        // Door stays open in IDLE only straight after reset; any transition closes it.
        if (w_state_nxt == S_DOOR_OPEN)  w_door_close_nxt = 1'b0;
        else if (w_state_nxt != r_state) w_door_close_nxt = 1'b1;
    end

    assign w_clr = (w_state_nxt == S_DOOR_OPEN && r_state != S_DOOR_OPEN) ? (ONE << w_flr_nxt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dir        <= DIR_UP;
            r_flr        <= '0;
            r_trav_cnt   <= '0;
            r_door_cnt   <= '0;
            r_req_up     <= '0;
            r_req_dn     <= '0;
            r_req_car    <= '0;
            r_door_close <= 1'b0;
            r_moving     <= 1'b0;
            r_moving_up  <= 1'b0;
            r_moving_dwn <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dir        <= w_dir_nxt;
            r_flr        <= w_flr_nxt;
            r_trav_cnt   <= w_trav_nxt;
            r_door_cnt   <= w_door_nxt;
            r_req_up     <= (r_req_up  | (w_set_up & w_set_mask)) & ~w_clr;
            r_req_dn     <= (r_req_dn  | (w_set_dn & w_set_mask)) & ~w_clr;
            r_req_car    <= (r_req_car | (car_btn  & w_set_mask)) & ~w_clr;
            r_door_close <= w_door_close_nxt;
            r_moving     <= (w_state_nxt == S_MOVE);
            r_moving_up  <= (w_state_nxt == S_MOVE) && (w_dir_nxt == DIR_UP);
            r_moving_dwn <= (w_state_nxt == S_MOVE) && (w_dir_nxt == DIR_DN);
        end
    end

    assign is_moving     = r_moving;
    assign is_moving_up  = r_moving_up;
    assign is_moving_dwn = r_moving_dwn;
    assign is_door_close = r_door_close;
    assign current_flr   = r_flr;
    assign pending       = w_req_all;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with the default 4-floor configuration.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_elevator_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hall_up_btn, hall_dwn_btn, car_btn;
    logic       is_moving, is_moving_up, is_moving_dwn, is_door_close;
    logic [1:0] current_flr;
    logic [3:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS(4), .FLR_W(2), .DOOR_CYCLES(8), .TRAVEL_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .hall_up_btn(hall_up_btn), .hall_dwn_btn(hall_dwn_btn), .car_btn(car_btn),
        .is_moving(is_moving), .is_moving_up(is_moving_up), .is_moving_dwn(is_moving_dwn),
        .is_door_close(is_door_close), .current_flr(current_flr), .pending(pending)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; hall_up_btn = '0; hall_dwn_btn = '0; car_btn = '0;
        step(2);
        chk("rst_flr", current_flr, 0);
        chk("rst_door", is_door_close, 0);
        chk("rst_mov", is_moving, 0);
        chk("rst_up", is_moving_up, 0);
        chk("rst_dn", is_moving_dwn, 0);
        chk("rst_pend", pending, 4'b0000);
        rst = 1'b0;

        // basic trip 0 -> 3
        car_btn = 4'b1000; step(1); car_btn = '0;
        chk("trip_pend", pending, 4'b1000);
        chk("trip_wait", is_moving, 0);
        step(1);
        chk("trip_up", is_moving_up, 1);
        chk("trip_f0", current_flr, 0);
        chk("trip_closed", is_door_close, 1);
        step(4);
        chk("trip_f1", current_flr, 1);
        chk("trip_mov1", is_moving, 1);
        step(4);
        chk("trip_f2", current_flr, 2);
        step(4);
        chk("trip_f3", current_flr, 3);
        chk("trip_open", is_door_close, 0);
        chk("trip_stop", is_moving, 0);
        chk("trip_clr", pending, 4'b0000);
        step(7);
        chk("trip_dwell", is_door_close, 0);
        step(1);
        chk("trip_close", is_door_close, 1);
        chk("trip_pend0", pending, 4'b0000);

        // ignored buttons, from a fresh reset at floor 0
        rst = 1'b1; step(1); rst = 1'b0;
        chk("ign_rst_flr", current_flr, 0);
        hall_up_btn = 4'b1000; hall_dwn_btn = 4'b0001; step(1);
        hall_up_btn = '0; hall_dwn_btn = '0;
        chk("ign_pend", pending, 4'b0000);
        step(3);
        chk("ign_pend2", pending, 4'b0000);
        chk("ign_idle", is_moving, 0);
        chk("ign_flr", current_flr, 0);
        chk("ign_door", is_door_close, 0);

        // SCAN order: visit 2, 3, then 1
        car_btn = 4'b1000; step(1); car_btn = '0;
        step(1);
        chk("scan_up", is_moving_up, 1);
        hall_dwn_btn = 4'b0010; car_btn = 4'b0100; step(1);
        hall_dwn_btn = '0; car_btn = '0;
        chk("scan_pend", pending, 4'b1110);
        step(6);
        chk("scan_pass1", current_flr, 1);
        chk("scan_mov1", is_moving, 1);
        step(1);
        chk("scan_f2", current_flr, 2);
        chk("scan_open2", is_door_close, 0);
        chk("scan_pend2", pending, 4'b1010);
        step(8);
        chk("scan_close2", is_door_close, 1);
        chk("scan_idle2", is_moving, 0);
        step(1);
        chk("scan_up2", is_moving_up, 1);
        step(4);
        chk("scan_f3", current_flr, 3);
        chk("scan_open3", is_door_close, 0);
        chk("scan_pend3", pending, 4'b0010);
        step(9);
        chk("scan_dn", is_moving_dwn, 1);
        chk("scan_dn_f3", current_flr, 3);
        step(4);
        chk("scan_pass2", current_flr, 2);
        chk("scan_mov2", is_moving, 1);
        step(4);
        chk("scan_f1", current_flr, 1);
        chk("scan_open1", is_door_close, 0);
        chk("scan_pend1", pending, 4'b0000);

        // door extend at floor 2
        step(8);
        chk("ext_closed1", is_door_close, 1);
        car_btn = 4'b0100; step(1); car_btn = '0;
        step(1);
        chk("ext_up", is_moving_up, 1);
        step(4);
        chk("ext_f2", current_flr, 2);
        chk("ext_open", is_door_close, 0);
        step(5);
        chk("ext_cycle6", is_door_close, 0);
        car_btn = 4'b0100; step(1); car_btn = '0;
        chk("ext_nolatch", pending[2], 0);
        chk("ext_open2", is_door_close, 0);
        step(3);
        chk("ext_held", is_door_close, 0);
        step(4);
        chk("ext_last", is_door_close, 0);
        step(1);
        chk("ext_close", is_door_close, 1);

        // reset while moving 2 -> 3
        car_btn = 4'b1001; step(1); car_btn = '0;
        step(2);
        chk("mrst_pend", pending, 4'b1001);
        chk("mrst_f2", current_flr, 2);
        chk("mrst_up", is_moving_up, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("mrst_flr", current_flr, 0);
        chk("mrst_pend0", pending, 4'b0000);
        chk("mrst_mov", is_moving, 0);
        chk("mrst_door", is_door_close, 0);
        step(3);
        chk("mrst_stay_pend", pending, 4'b0000);
        chk("mrst_stay_flr", current_flr, 0);
        chk("mrst_stay_mov", is_moving, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
